// File: rtl/mask_allocator_pkg.sv
// Shared constants for the entry allocator: default sizing and derived widths.
package mask_allocator_pkg;

    localparam int ENTRY_NUM_DEF = 16;
    localparam int REQ_MAX_DEF   = 4;

    // Derived widths for the default sizing: entry index, free count, request count.
    localparam int IDX_W_DEF = $clog2(ENTRY_NUM_DEF);
    localparam int CNT_W_DEF = IDX_W_DEF + 1;
    localparam int REQ_W_DEF = $clog2(REQ_MAX_DEF + 1);

endpackage

// File: rtl/one_counter.sv
// Population count of a bit vector, fully combinational.
module one_counter #(
    parameter int W  = 16,
    parameter int CW = $clog2(W) + 1
) (
    input  logic [W-1:0]  bits_i,
    output logic [CW-1:0] cnt_o
);

    // Unrolled adder chain over every input bit.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/mask_allocator.sv
// Free-list allocator: grants the lowest-index free entries from a bitmap,
// accepts releases and a flush, and tracks a registered free count and a
// sticky illegal-release flag.
module mask_allocator
    import mask_allocator_pkg::*;
#(
    parameter int ENTRY_NUM = ENTRY_NUM_DEF,
    parameter int REQ_MAX   = REQ_MAX_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alloc_vld_i,
    input  logic [$clog2(REQ_MAX+1)-1:0]   alloc_cnt_i,
    output logic                           alloc_rdy_o,
    output logic [ENTRY_NUM-1:0]           alloc_mask_o,
    input  logic                           release_vld_i,
    input  logic [ENTRY_NUM-1:0]           release_mask_i,
    input  logic                           flush_i,
    output logic [$clog2(ENTRY_NUM):0]     free_cnt_o,
    output logic                           err_o
);

    localparam int CW = $clog2(ENTRY_NUM) + 1;
    localparam int RW = $clog2(REQ_MAX + 1);

    logic [ENTRY_NUM-1:0] free_q;
    logic [ENTRY_NUM-1:0] free_d;
    logic [CW-1:0]        free_cnt_d;
    logic                 err_d;
    logic                 fire;
    logic [CW-1:0]        taken;

    // Lowest-N select: each entry is granted if free and fewer than N lower
    // entries have already been granted. Grants look at free_q only, so
    // entries released this cycle cannot be handed out until the next one.
    always_comb begin
        alloc_mask_o = '0;
        taken        = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (free_q[i] && (taken < CW'(alloc_cnt_i))) begin
                alloc_mask_o[i] = 1'b1;
                taken           = taken + 1'b1;
            end
        end
    end

    // Ready needs enough free entries, a legal count, and no flush in progress.
    always_comb begin
        alloc_rdy_o = (free_cnt_o >= CW'(alloc_cnt_i)) &&
                      (alloc_cnt_i <= RW'(REQ_MAX)) &&
                      !flush_i;
        fire        = alloc_vld_i && alloc_rdy_o;
    end

    // Next bitmap: flush wins; otherwise clear granted bits and set released
    // ones. Releasing an entry that is already free raises the sticky error.
    always_comb begin
        free_d = free_q;
        err_d  = err_o;
        if (release_vld_i && |(release_mask_i & free_q)) begin
            err_d = 1'b1;
        end
        if (flush_i) begin
            free_d = '1;
        end else begin
            if (fire) begin
                free_d = free_d & ~alloc_mask_o;
            end
            if (release_vld_i) begin
                free_d = free_d | release_mask_i;
            end
        end
    end

    one_counter #(
        .W  (ENTRY_NUM),
        .CW (CW)
    ) u_free_cnt (
        .bits_i (free_d),
        .cnt_o  (free_cnt_d)
    );

    // State registers; the count is registered from next-state so it always
    // matches the bitmap it sits beside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q     <= '1;
            free_cnt_o <= CW'(ENTRY_NUM);
            err_o      <= 1'b0;
        end else begin
            free_q     <= free_d;
            free_cnt_o <= free_cnt_d;
            err_o      <= err_d;
        end
    end

endmodule
